// File: rtl/vitals_classifier.sv
// Classifies 8-bit sensor samples into NORMAL/BORDERLINE/ATTENTION/EMERGENCY with hysteresis and
// an N-sample confirmation filter. Define EMERG_LATCH_EN to hold EMERGENCY until ack.
module vitals_classifier #(
    parameter int T_BORDER = 100,
    parameter int T_ATTN   = 140,
    parameter int T_EMERG  = 180,
    parameter int HYST     = 8,
    parameter int CONFIRM  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    input  logic       ack,
    output logic [3:0] state,
    output logic       state_changed,
    output logic       alarm
);

    typedef enum logic [3:0] {
        NORMAL     = 4'd0,
        BORDERLINE = 4'd1,
        ATTENTION  = 4'd2,
        EMERGENCY  = 4'd3
    } alert_t;

    localparam logic [8:0] T_BORDER9 = 9'(T_BORDER);
    localparam logic [8:0] T_ATTN9   = 9'(T_ATTN);
    localparam logic [8:0] T_EMERG9  = 9'(T_EMERG);
    localparam logic [8:0] HYST9     = 9'(HYST);
    localparam logic [3:0] CONFIRM4  = 4'(CONFIRM);

    alert_t     cur_q, cur_d;
    alert_t     cand_q, cand_d;
    alert_t     level;
    logic [3:0] count_q, count_d, count_upd;
    logic       changed_q, changed_d;
    logic       alarm_q;
    logic       take_sample;
    logic [8:0] eff_border, eff_attn, eff_emerg;
    logic [8:0] sample9;

`ifdef EMERG_LATCH_EN
    logic       latch_q, latch_d;
    logic       ack_clear;
`else
    logic       ack_unused;
    assign ack_unused = ack;
`endif

    // Levels at or below the current state are lowered by HYST so a reading
    // hovering on a threshold does not make the state chatter downwards.
    function automatic logic [8:0] eff_thresh(input logic [8:0] t, input logic lowered);
        if (!lowered)
            return t;
        else if (t >= HYST9)
            return t - HYST9;
        else
            return 9'd0;
    endfunction

    assign sample9    = {1'b0, sample};
    assign eff_border = eff_thresh(T_BORDER9, cur_q >= BORDERLINE);
    assign eff_attn   = eff_thresh(T_ATTN9,   cur_q >= ATTENTION);
    assign eff_emerg  = eff_thresh(T_EMERG9,  cur_q >= EMERGENCY);

    always_comb begin
        level = NORMAL;
        if (sample9 >= eff_emerg)
            level = EMERGENCY;
        else if (sample9 >= eff_attn)
            level = ATTENTION;
        else if (sample9 >= eff_border)
            level = BORDERLINE;
    end

`ifdef EMERG_LATCH_EN
    assign ack_clear   = ack && latch_q;
    assign take_sample = sample_valid && !latch_q && !ack_clear;
`else
    assign take_sample = sample_valid;
`endif

    always_comb begin
        cur_d     = cur_q;
        cand_d    = cand_q;
        count_d   = count_q;
        count_upd = count_q;
        changed_d = 1'b0;
`ifdef EMERG_LATCH_EN
        latch_d   = latch_q;
        if (ack_clear) begin
            latch_d   = 1'b0;
            cur_d     = NORMAL;
            cand_d    = NORMAL;
            count_d   = 4'd0;
            changed_d = 1'b1;
        end
`endif
        if (take_sample) begin
            if (level == cur_q) begin
                count_d = 4'd0;
            end else begin
                if (level == cand_q) begin
                    count_upd = count_q + 4'd1;
                end else begin
                    cand_d    = level;
                    count_upd = 4'd1;
                end
                if (count_upd >= CONFIRM4) begin
                    cur_d     = cand_d;
                    count_d   = 4'd0;
                    changed_d = 1'b1;
`ifdef EMERG_LATCH_EN
                    latch_d   = (cand_d == EMERGENCY);
`endif
                end else begin
                    count_d = count_upd;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q     <= NORMAL;
            cand_q    <= NORMAL;
            count_q   <= 4'd0;
            changed_q <= 1'b0;
            alarm_q   <= 1'b0;
`ifdef EMERG_LATCH_EN
            latch_q   <= 1'b0;
`endif
        end else begin
            cur_q     <= cur_d;
            cand_q    <= cand_d;
            count_q   <= count_d;
            changed_q <= changed_d;
            alarm_q   <= (cur_d == EMERGENCY);
`ifdef EMERG_LATCH_EN
            latch_q   <= latch_d;
`endif
        end
    end

    assign state         = cur_q;
    assign state_changed = changed_q;
    assign alarm         = alarm_q;

endmodule

// File: tb/tb_vitals_classifier.sv
// Self-checking bench for vitals_classifier: directed scenarios followed by
// randomized samples, acks and mid-cycle resets against a rule-level model.
module tb_vitals_classifier;

`ifdef EMERG_LATCH_EN
    localparam bit LATCH_EN = 1'b1;
`else
    localparam bit LATCH_EN = 1'b0;
`endif
    localparam int HYST    = 8;
    localparam int CONFIRM = 3;

    logic       clk;
    logic       rst_n;
    logic       sample_valid;
    logic [7:0] sample;
    logic       ack;
    logic [3:0] state;
    logic       state_changed;
    logic       alarm;

    int n_checks;
    int n_fail;

    int m_state, m_cand, m_count, m_latch;
    int exp_changed;

    vitals_classifier dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .ack          (ack),
        .state        (state),
        .state_changed(state_changed),
        .alarm        (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Highest level whose (possibly hysteresis-lowered) threshold the reading meets.
    function automatic int levelOf(input int s, input int cur);
        int thr[3] = '{100, 140, 180};
        int lvl = 0;
        for (int k = 1; k <= 3; k++) begin
            int th = thr[k-1];
            if (k <= cur) th = (th > HYST) ? th - HYST : 0;
            if (s >= th) lvl = k;
        end
        return lvl;
    endfunction

    task automatic modelReset();
        m_state = 0; m_cand = 0; m_count = 0; m_latch = 0; exp_changed = 0;
    endtask

    task automatic modelStep(input bit v, input int s, input bit a);
        int lvl;
        exp_changed = 0;
        if (LATCH_EN && a && m_latch == 1) begin
            m_latch = 0; m_state = 0; m_cand = 0; m_count = 0; exp_changed = 1;
        end else if (v && m_latch == 0) begin
            lvl = levelOf(s, m_state);
            if (lvl == m_state) begin
                m_count = 0;
            end else begin
                if (lvl == m_cand) m_count = m_count + 1;
                else begin m_cand = lvl; m_count = 1; end
                if (m_count == CONFIRM) begin
                    m_state = m_cand; m_count = 0; exp_changed = 1;
                    if (LATCH_EN && m_state == 3) m_latch = 1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs, let the edge capture them, then compare with the model.
    task automatic applyStimulus(input bit v, input int s, input bit a);
        sample_valid = v;
        sample       = 8'(s);
        ack          = a;
        @(posedge clk);
        #1;
        modelStep(v, s, a);
        checkOutput("state", 32'(state), 32'(m_state));
        checkOutput("state_changed", 32'(state_changed), 32'(exp_changed));
        checkOutput("alarm", 32'(alarm), 32'(m_state == 3));
        sample_valid = 1'b0;
        ack          = 1'b0;
    endtask

    task automatic repeatSample(input int s, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, s, 1'b0);
    endtask

    // Reset lands mid-cycle; outputs must clear before any clock edge.
    task automatic midCycleReset();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_alarm", 32'(alarm), 32'd0);
        checkOutput("rst_changed", 32'(state_changed), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = 8'd0;
        ack          = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", 32'(state), 32'd0);
        checkOutput("reset_changed", 32'(state_changed), 32'd0);
        checkOutput("reset_alarm", 32'(alarm), 32'd0);
        rst_n = 1'b1;

        repeat (5) applyStimulus(1'b1, 50, 1'b0);
        checkOutput("normal_hold", 32'(state), 32'd0);

        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        checkOutput("attn_state", 32'(state), 32'd2);
        checkOutput("attn_pulse", 32'(state_changed), 32'd1);
        applyStimulus(1'b0, 0, 1'b0);
        checkOutput("attn_pulse_end", 32'(state_changed), 32'd0);

        midCycleReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 150, 1'b0);
            if (i < 2) repeat (4) applyStimulus(1'b0, 0, 1'b0);
        end
        checkOutput("gap_attn_state", 32'(state), 32'd2);

        midCycleReset();
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 120, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        applyStimulus(1'b1, 150, 1'b0);
        checkOutput("broken_streak", 32'(state), 32'd0);
        applyStimulus(1'b1, 150, 1'b0);
        checkOutput("streak_resumed", 32'(state), 32'd2);

        repeatSample(135, 5);
        checkOutput("hyst_hold", 32'(state), 32'd2);
        repeatSample(131, 3);
        checkOutput("hyst_drop", 32'(state), 32'd1);

        midCycleReset();
        repeatSample(200, 3);
        checkOutput("emerg_state", 32'(state), 32'd3);
        checkOutput("emerg_alarm", 32'(alarm), 32'd1);
        repeatSample(50, 3);
        if (LATCH_EN) begin
            checkOutput("latched_state", 32'(state), 32'd3);
            applyStimulus(1'b1, 200, 1'b1);
            checkOutput("ack_state", 32'(state), 32'd0);
            checkOutput("ack_pulse", 32'(state_changed), 32'd1);
        end else begin
            checkOutput("deescalate_state", 32'(state), 32'd0);
            checkOutput("deescalate_alarm", 32'(alarm), 32'd0);
        end

        applyStimulus(1'b1, 200, 1'b0);
        applyStimulus(1'b1, 200, 1'b0);
        midCycleReset();
        applyStimulus(1'b1, 200, 1'b0);
        checkOutput("post_reset_single", 32'(state), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int pick, s;
            int bases[8] = '{100, 140, 180, 92, 132, 172, 0, 255};
            pick = int'($urandom_range(0, 9));
            if (pick < 8) begin
                s = bases[pick] + int'($urandom_range(0, 6)) - 3;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
            end else begin
                s = int'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 399) == 0)
                midCycleReset();
            else
                applyStimulus($urandom_range(0, 9) < 7, s, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
